// File: rtl/wb_arbiter_if.sv
// Write-back bus between the functional units and the write-back arbiter.
// The master side is the FU/register-file environment; the slave side is the arbiter.
interface wb_arbiter_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned NFU = 5
);
    logic [NFU-1:0]     fu_valid;
    logic [NFU-1:0]     fu_ready;
    logic [5*NFU-1:0]   fu_rd;
    logic [DW*NFU-1:0]  fu_data;
    logic               wb_en;
    logic [4:0]         wb_rd;
    logic [DW-1:0]      wb_data;
    logic [2:0]         wb_src;
    logic [NFU-1:0]     done;
    logic               busy;

    modport master (
        output fu_valid, fu_rd, fu_data,
        input  fu_ready, wb_en, wb_rd, wb_data, wb_src, done, busy
    );

    modport slave (
        input  fu_valid, fu_rd, fu_data,
        output fu_ready, wb_en, wb_rd, wb_data, wb_src, done, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per functional unit, round-robin grant of a
// single full slot per cycle onto a registered register-file write port.
module wb_arbiter #(
    parameter int unsigned DW  = 32,
    parameter int unsigned NFU = 5   // at most 8, wb_src is 3 bits
) (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active low
    wb_arbiter_if.slave bus
);

    logic [NFU-1:0]          full_q, full_d;
    logic [NFU-1:0][4:0]     rd_q;
    logic [NFU-1:0][DW-1:0]  data_q;
    logic [2:0]              ptr_q, ptr_d;

    logic                    wb_en_q;
    logic [4:0]              wb_rd_q;
    logic [DW-1:0]           wb_data_q;
    logic [2:0]              wb_src_q;
    logic [NFU-1:0]          done_q;

    logic                    gnt_valid;
    logic [2:0]              gnt_idx;
    logic [NFU-1:0]          gnt_oh;
    logic [NFU-1:0]          ready;
    logic [NFU-1:0]          load;

    // Round-robin pick of the first full slot at or after ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        // Walk from the far end so the closest slot to ptr wins last.
        for (int k = NFU - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= int'(NFU)) begin
                idx = idx - int'(NFU);
            end
            if (full_q[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(idx);
                gnt_oh    = '0;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    // Slot acceptance and next-state of full flags and pointer.
    always_comb begin
        ready  = ~full_q | gnt_oh;
        load   = bus.fu_valid & ready;
        // A granted slot that is reloaded in the same cycle stays full.
        full_d = load | (full_q & ~gnt_oh);
        ptr_d  = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == 3'(NFU - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

    // Holding slots and arbitration pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            for (int i = 0; i < int'(NFU); i++) begin
                if (load[i]) begin
                    rd_q[i]   <= bus.fu_rd[5*i +: 5];
                    data_q[i] <= bus.fu_data[DW*i +: DW];
                end
            end
        end
    end

    // Registered write-back port; address/data/source hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_src_q  <= '0;
            done_q    <= '0;
        end else if (gnt_valid) begin
            wb_en_q   <= (rd_q[gnt_idx] != 5'd0);
            wb_rd_q   <= rd_q[gnt_idx];
            wb_data_q <= data_q[gnt_idx];
            wb_src_q  <= gnt_idx;
            done_q    <= gnt_oh;
        end else begin
            wb_en_q   <= 1'b0;
            done_q    <= '0;
        end
    end

    assign bus.fu_ready = ready;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_src   = wb_src_q;
    assign bus.done     = done_q;
    assign bus.busy     = (|full_q) | wb_en_q | (|done_q);

endmodule
